// File: rtl/brownout_supervisor.sv
// Brownout supervisor: digital controller on the far side of the brownout
// detector. Drives the detector configuration (ena/otrip/vtrip), synchronizes
// its asynchronous status outputs, blanks them while the detector settles,
// and turns a brownout into a debounced, stretched active-low system reset.
// Sticky brownout/undervoltage/timeout flags are kept for software, with an
// interrupt raised while either of the first two is set.
//
// Ports
//   ck, resetb               clock, asynchronous active-low reset
//   cfg_en, cfg_otrip/vtrip  software enable and requested trip codes
//   clr_brout, clr_vunder    one-cycle flag clear pulses
//   bod_out/vunder/timed_out asynchronous detector status inputs
//   ena, otrip, vtrip        detector configuration (registered)
//   sys_resetb               active-low system reset request
//   brout_flag, vunder_flag, timeout_flag, irq   sticky status, interrupt
//   state                    OFF=0 SETTLE=1 MONITOR=2 BROWNOUT=3 HOLD=4
module brownout_supervisor #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 64,
  parameter int DEB_CYC     = 8,
  parameter int RST_HOLD    = 256
) (
  input  logic       ck,
  input  logic       resetb,
  input  logic       cfg_en,
  input  logic [2:0] cfg_otrip,
  input  logic [2:0] cfg_vtrip,
  input  logic       clr_brout,
  input  logic       clr_vunder,
  input  logic       bod_out,
  input  logic       bod_vunder,
  input  logic       bod_timed_out,
  output logic       ena,
  output logic [2:0] otrip,
  output logic [2:0] vtrip,
  output logic       sys_resetb,
  output logic       brout_flag,
  output logic       vunder_flag,
  output logic       timeout_flag,
  output logic       irq,
  output logic [2:0] state
);

  localparam int MAX_A = (SETTLE_CYC > DEB_CYC) ? SETTLE_CYC : DEB_CYC;
  localparam int MAXC  = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    SETTLE   = 3'd1,
    MONITOR  = 3'd2,
    BROWNOUT = 3'd3,
    HOLD     = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   ena_q, rstb_q;
  logic [2:0]             otrip_q, vtrip_q;
  logic                   brout_q, vunder_q, timeout_q, irq_q;
  logic                   brout_d, vunder_d, timeout_d;
  logic [SYNC_STAGES-1:0] sync_out_q, sync_vun_q, sync_to_q;
  logic                   s_out, s_vun, s_to, watch, codes_differ;

  // Plain flop chains; bit 0 captures the raw asynchronous input.
  always_ff @(posedge ck or negedge resetb) begin
    if (!resetb) begin
      sync_out_q <= '0;
      sync_vun_q <= '0;
      sync_to_q  <= '0;
    end else begin
      sync_out_q <= {sync_out_q[SYNC_STAGES-2:0], bod_out};
      sync_vun_q <= {sync_vun_q[SYNC_STAGES-2:0], bod_vunder};
      sync_to_q  <= {sync_to_q[SYNC_STAGES-2:0], bod_timed_out};
    end
  end

  assign s_out = sync_out_q[SYNC_STAGES-1];
  assign s_vun = sync_vun_q[SYNC_STAGES-1];
  assign s_to  = sync_to_q[SYNC_STAGES-1];

  assign codes_differ = (cfg_otrip != otrip_q) || (cfg_vtrip != vtrip_q);

  // Detector status is trusted only once settled (MONITOR and the recovery
  // states). Set beats clear, so an event coinciding with a clear survives.
  always_comb begin
    watch     = (state_q == MONITOR) || (state_q == BROWNOUT) || (state_q == HOLD);
    brout_d   = ((state_q == MONITOR) && s_out) || (brout_q && !clr_brout);
    vunder_d  = (watch && s_vun) || (vunder_q && !clr_vunder);
    timeout_d = (watch && s_to) || timeout_q;
  end

  always_ff @(posedge ck or negedge resetb) begin
    if (!resetb) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      ena_q     <= 1'b0;
      otrip_q   <= 3'd0;
      vtrip_q   <= 3'd0;
      rstb_q    <= 1'b1;
      brout_q   <= 1'b0;
      vunder_q  <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      brout_q   <= brout_d;
      vunder_q  <= vunder_d;
      timeout_q <= timeout_d;
      irq_q     <= brout_d | vunder_d;
      case (state_q)
        OFF: begin
          ena_q <= 1'b0;
          if (cfg_en) begin
            state_q <= SETTLE;
            ena_q   <= 1'b1;
            otrip_q <= cfg_otrip;
            vtrip_q <= cfg_vtrip;
            cnt_q   <= CW'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (!cfg_en) begin
            state_q <= OFF;
            ena_q   <= 1'b0;
          end else if (codes_differ) begin
            // New trip code restarts the blanking window.
            otrip_q <= cfg_otrip;
            vtrip_q <= cfg_vtrip;
            cnt_q   <= CW'(SETTLE_CYC - 1);
          end else if (cnt_q == '0) begin
            state_q <= MONITOR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MONITOR: begin
          if (s_out) begin
            state_q <= BROWNOUT;
            rstb_q  <= 1'b0;
            cnt_q   <= CW'(DEB_CYC - 1);
          end else if (!cfg_en) begin
            state_q <= OFF;
            ena_q   <= 1'b0;
          end else if (codes_differ) begin
            state_q <= SETTLE;
            otrip_q <= cfg_otrip;
            vtrip_q <= cfg_vtrip;
            cnt_q   <= CW'(SETTLE_CYC - 1);
          end
        end
        // Software cannot abort a brownout: cfg inputs are ignored until the
        // reset has been fully stretched and we are back in MONITOR.
        BROWNOUT: begin
          rstb_q <= 1'b0;
          if (s_out) begin
            cnt_q <= CW'(DEB_CYC - 1);
          end else if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= CW'(RST_HOLD - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          rstb_q <= 1'b0;
          if (s_out) begin
            state_q <= BROWNOUT;
            cnt_q   <= CW'(DEB_CYC - 1);
          end else if (cnt_q == '0) begin
            state_q <= MONITOR;
            rstb_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          // Illegal encodings recover to OFF; flags are left untouched.
          state_q <= OFF;
          cnt_q   <= '0;
          ena_q   <= 1'b0;
          otrip_q <= 3'd0;
          vtrip_q <= 3'd0;
          rstb_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ena          = ena_q;
  assign otrip        = otrip_q;
  assign vtrip        = vtrip_q;
  assign sys_resetb   = rstb_q;
  assign brout_flag   = brout_q;
  assign vunder_flag  = vunder_q;
  assign timeout_flag = timeout_q;
  assign irq          = irq_q;
  assign state        = state_q;

endmodule

// File: tb/tb_brownout_supervisor.sv
module tb_brownout_supervisor;
  localparam int SS = 2, SC = 64, DC = 8, RH = 256;

  logic ck = 1'b0, resetb = 1'b0;
  always #5 ck = ~ck;

  logic       cfg_en = 0, clr_brout = 0, clr_vunder = 0;
  logic [2:0] cfg_otrip = 0, cfg_vtrip = 0;
  logic       bod_out = 0, bod_vunder = 0, bod_timed_out = 0;
  logic       ena, sys_resetb, brout_flag, vunder_flag, timeout_flag, irq;
  logic [2:0] otrip, vtrip, state;

  brownout_supervisor #(.SYNC_STAGES(SS), .SETTLE_CYC(SC), .DEB_CYC(DC), .RST_HOLD(RH)) dut (
    .ck(ck), .resetb(resetb), .cfg_en(cfg_en), .cfg_otrip(cfg_otrip), .cfg_vtrip(cfg_vtrip),
    .clr_brout(clr_brout), .clr_vunder(clr_vunder), .bod_out(bod_out), .bod_vunder(bod_vunder),
    .bod_timed_out(bod_timed_out), .ena(ena), .otrip(otrip), .vtrip(vtrip),
    .sys_resetb(sys_resetb), .brout_flag(brout_flag), .vunder_flag(vunder_flag),
    .timeout_flag(timeout_flag), .irq(irq), .state(state));

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model. Blanking is tracked as edges elapsed since entering
  // SETTLE; recovery as the run of consecutive quiet edges since the last
  // synchronized brownout sample (reset releases after DC+RH quiet edges).
  logic [2:0] m_state, m_otrip, m_vtrip;
  logic       m_ena, m_rstb, m_br, m_vu, m_to, m_irq;
  int         elapsed, quiet;
  logic       ho[SS], hv[SS], ht[SS];

  task automatic model_reset();
    m_state = 0; m_otrip = 0; m_vtrip = 0; m_ena = 0; m_rstb = 1;
    m_br = 0; m_vu = 0; m_to = 0; m_irq = 0; elapsed = 0; quiet = 0;
    for (int i = 0; i < SS; i++) begin ho[i] = 0; hv[i] = 0; ht[i] = 0; end
  endtask

  task automatic model_step();
    logic so, sv, st, active, differ;
    so = ho[SS-1]; sv = hv[SS-1]; st = ht[SS-1];
    active = (m_state >= 2 && m_state <= 4);
    differ = (cfg_otrip != m_otrip) || (cfg_vtrip != m_vtrip);
    m_br  = (m_state == 2 && so) | (m_br & ~clr_brout);
    m_vu  = (active && sv) | (m_vu & ~clr_vunder);
    m_to  = (active && st) | m_to;
    m_irq = m_br | m_vu;
    case (m_state)
      0: if (cfg_en) begin
           m_state = 1; m_ena = 1; m_otrip = cfg_otrip; m_vtrip = cfg_vtrip; elapsed = 0;
         end
      1: if (!cfg_en) begin m_state = 0; m_ena = 0; end
         else if (differ) begin m_otrip = cfg_otrip; m_vtrip = cfg_vtrip; elapsed = 0; end
         else begin elapsed++; if (elapsed == SC) m_state = 2; end
      2: if (so) begin m_state = 3; m_rstb = 0; quiet = 0; end
         else if (!cfg_en) begin m_state = 0; m_ena = 0; end
         else if (differ) begin
           m_state = 1; m_otrip = cfg_otrip; m_vtrip = cfg_vtrip; elapsed = 0;
         end
      default: if (so) begin m_state = 3; quiet = 0; end
         else begin
           quiet++;
           if (quiet == DC + RH) begin m_state = 2; m_rstb = 1; end
           else m_state = (quiet >= DC) ? 3'd4 : 3'd3;
         end
    endcase
    for (int i = SS - 1; i > 0; i--) begin ho[i] = ho[i-1]; hv[i] = hv[i-1]; ht[i] = ht[i-1]; end
    ho[0] = bod_out; hv[0] = bod_vunder; ht[0] = bod_timed_out;
  endtask

  always @(posedge ck or negedge resetb) begin
    if (!resetb) model_reset();
    else model_step();
  end

  function automatic logic [14:0] dut_pack();
    return {state, ena, otrip, vtrip, sys_resetb, brout_flag, vunder_flag, timeout_flag, irq};
  endfunction
  function automatic logic [14:0] mdl_pack();
    return {m_state, m_ena, m_otrip, m_vtrip, m_rstb, m_br, m_vu, m_to, m_irq};
  endfunction

  // One clock, then compare every output to the model away from the edge.
  task automatic cyc();
    @(posedge ck); #1;
    check("outs", 32'(dut_pack()), 32'(mdl_pack()));
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    do begin cyc(); n++; end while (state != s && n < limit);
    if (state != s) n = -1;
  endtask

  int n, t_low, t_high, saw_bo;

  initial begin
    // Reset state
    #12;
    check("rst_state", state, 0);  check("rst_ena", ena, 0);
    check("rst_rstb", sys_resetb, 1); check("rst_irq", irq, 0);
    @(posedge ck); #1 resetb = 1;

    // Enable and settle; a bod_out pulse inside the blanking window is ignored
    cfg_en = 1; cfg_otrip = 3'd5; cfg_vtrip = 3'd2;
    cyc();
    check("en_ena", ena, 1); check("en_otrip", otrip, 5);
    check("en_vtrip", vtrip, 2); check("en_state", state, 1);
    n = 0;
    do begin
      if (n == 10) bod_out = 1;
      if (n == 13) bod_out = 0;
      cyc(); n++;
    end while (state != 2 && n < 200);
    check("settle_len", n, SC);
    check("settle_noflag", brout_flag, 0); check("settle_rstb", sys_resetb, 1);

    // Brownout: 20 high edges, then quiet. Synchronized high at edges 3..22,
    // so the last required quiet edge is SS + 20 + DC + RH.
    bod_out = 1; t_low = 0; t_high = 0;
    for (int i = 1; i <= 1000; i++) begin
      cyc();
      if (i == 20) bod_out = 0;
      if (sys_resetb == 0 && t_low == 0) t_low = i;
      if (sys_resetb == 1 && t_low != 0) begin t_high = i; break; end
    end
    check("bo_latency", t_low, SS + 1);
    check("bo_release", t_high, SS + 20 + DC + RH);
    check("bo_flag", brout_flag, 1); check("bo_irq", irq, 1);
    check("bo_state", state, 2);

    // Glitch 100 cycles into HOLD restarts the whole debounce+hold sequence
    bod_out = 1; cyc(); bod_out = 0;
    wait_state(3'd4, 100, n); check("reach_hold", (n > 0), 1);
    repeat (100) cyc();
    bod_out = 1; cyc(); bod_out = 0;
    n = 1; saw_bo = 0;
    while (sys_resetb == 0 && n < 1000) begin
      cyc(); n++;
      if (state == 3) saw_bo = 1;
    end
    check("glitch_bo", saw_bo, 1);
    check("glitch_len", n, SS + 1 + DC + RH);

    // Retune then disable
    cfg_otrip = 3'd6; cyc();
    check("retune_state", state, 1); check("retune_otrip", otrip, 6);
    wait_state(3'd2, 200, n); check("retune_len", n, SC);
    cfg_en = 0; cyc();
    check("dis_state", state, 0); check("dis_ena", ena, 0);

    // Flags
    cfg_en = 1; cyc(); wait_state(3'd2, 200, n);
    bod_vunder = 1; repeat (3) cyc();
    check("vun_set", vunder_flag, 1); check("vun_state", state, 2);
    clr_vunder = 1; cyc(); clr_vunder = 0; cyc();
    check("vun_setwins", vunder_flag, 1);
    bod_vunder = 0; repeat (3) cyc();
    clr_vunder = 1; clr_brout = 1; cyc(); clr_vunder = 0; clr_brout = 0;
    check("vun_clr", vunder_flag, 0); check("br_clr", brout_flag, 0);
    check("irq_clr", irq, 0);

    // Asynchronous reset in the middle of HOLD
    bod_out = 1; cyc(); bod_out = 0;
    wait_state(3'd4, 100, n); repeat (20) cyc();
    check("pre_rst_hold", state, 4);
    resetb = 0; #1;
    check("arst_rstb", sys_resetb, 1); check("arst_ena", ena, 0);
    check("arst_state", state, 0); check("arst_flags", {brout_flag, vunder_flag, timeout_flag, irq}, 0);
    check("arst_model", 32'(dut_pack()), 32'(mdl_pack()));
    @(posedge ck); #1 resetb = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) cfg_en = ~cfg_en;
      if ($urandom_range(0, 299) == 0) cfg_otrip = 3'($urandom);
      if ($urandom_range(0, 299) == 0) cfg_vtrip = 3'($urandom);
      if (bod_out) bod_out = ($urandom_range(0, 5) != 0);
      else bod_out = ($urandom_range(0, 149) == 0);
      if (bod_vunder) bod_vunder = ($urandom_range(0, 3) != 0);
      else bod_vunder = ($urandom_range(0, 99) == 0);
      bod_timed_out = ($urandom_range(0, 499) == 0);
      clr_brout = ($urandom_range(0, 39) == 0);
      clr_vunder = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/brownout_supervisor.md
Name: brownout_supervisor

Overview:
- Digital controller on the far side of the brownout detector interface.
- Drives the detector's configuration inputs: ena, otrip, vtrip.
- Consumes its asynchronous status outputs (out, vunder, timed_out), synchronizes them, and sequences enable/settle blanking.
- Generates a debounced, stretched active-low system reset plus sticky brownout/undervoltage flags and an interrupt for the SoC.

Parameters:
SYNC_STAGES, 2, flip-flop depth of synchronizers on bod_out, bod_vunder, bod_timed_out (min 2)
SETTLE_CYC, 64, ck cycles of blanking after enable or trip-code change (min 1)
DEB_CYC, 8, consecutive cycles bod_out must read low before recovery starts (min 1)
RST_HOLD, 256, ck cycles sys_resetb held low after debounce completes (min 1)

Ports:
- ck  input  1  system clock
- resetb  input  1  asynchronous active-low reset
- cfg_en  input  1  software enable for the brownout detector
- cfg_otrip  input  3  requested brownout trip code
- cfg_vtrip  input  3  requested undervoltage trip code
- clr_brout  input  1  one-cycle pulse, clears brout_flag
- clr_vunder  input  1  one-cycle pulse, clears vunder_flag
- bod_out  input  1  detector brownout output, asynchronous
- bod_vunder  input  1  detector undervoltage output, asynchronous
- bod_timed_out  input  1  detector oneshot timeout debug output, asynchronous
- ena  output  1  detector enable
- otrip  output  3  latched trip code to detector
- vtrip  output  3  latched trip code to detector
- sys_resetb  output  1  active-low system reset request
- brout_flag  output  1  sticky brownout event
- vunder_flag  output  1  sticky undervoltage event
- timeout_flag  output  1  sticky oneshot timeout event
- irq  output  1  brout_flag | vunder_flag
- state  output  3  FSM state: OFF=0, SETTLE=1, MONITOR=2, BROWNOUT=3, HOLD=4

Behaviour:
- Clocking and reset: one clock ck; reset resetb is asynchronous, active-low.
- Reset values: state=OFF, ena=0, otrip=0, vtrip=0, sys_resetb=1, all flags=0, irq=0, counter=0, synchronizers=0.
- Registered outputs: all outputs are registered; none are combinational from inputs.
- Synchronizers: s_out, s_vun, s_to are the SYNC_STAGES-deep synchronized versions of bod_out, bod_vunder, bod_timed_out. Only synchronized values are used.
- Counter: one shared down-counter, width $clog2(max(SETTLE_CYC, DEB_CYC, RST_HOLD)+1).
- OFF:
  - ena=0.
  - cfg_en=1 -> SETTLE. Same edge: otrip<=cfg_otrip, vtrip<=cfg_vtrip, ena<=1, counter<=SETTLE_CYC-1.
- SETTLE:
  - s_out, s_vun, s_to ignored.
  - counter decrements each cycle; counter==0 -> MONITOR.
  - cfg_en=0 -> OFF, ena<=0. This takes priority over all other SETTLE transitions.
  - cfg_otrip/cfg_vtrip differing from the latched codes -> relatch and reload counter to SETTLE_CYC-1 (stay in SETTLE).
- MONITOR, checked in priority order:
  1. s_out=1 -> BROWNOUT: sys_resetb<=0, brout_flag<=1, counter<=DEB_CYC-1.
  2. cfg_en=0 -> OFF, ena<=0.
  3. Trip code change -> SETTLE with relatch and counter reload.
  - Regardless of transition: s_vun=1 sets vunder_flag; s_to=1 sets timeout_flag.
  - Latency: bod_out rising to sys_resetb low is SYNC_STAGES+1 ck edges.
- BROWNOUT:
  - sys_resetb=0.
  - cfg_en and cfg trip inputs are ignored; software cannot abort an event.
  - s_out=1 reloads counter to DEB_CYC-1.
  - s_out=0 decrements counter; s_out=0 with counter==0 -> HOLD, counter<=RST_HOLD-1.
- HOLD:
  - sys_resetb=0.
  - s_out=1 -> BROWNOUT, counter<=DEB_CYC-1.
  - Otherwise decrement; counter==0 -> MONITOR, sys_resetb<=1.
  - cfg changes are ignored. If cfg_en=0 or the codes differ on return, MONITOR handles them next cycle.
- vunder_flag and timeout_flag are also set in BROWNOUT and HOLD. They are never set in OFF or SETTLE.
- Flag clearing: a clr_* pulse clears its flag. Set and clear in the same cycle -> flag stays 1 (set wins). clr_brout has no effect on FSM or sys_resetb.
- irq is registered: irq<=next brout_flag | next vunder_flag, so it changes on the same edge as the flags.
- Unused state codes 5-7 -> OFF with reset output values, except that flags are kept.

Test Plan:
- Enable/settle: reset, cfg_en=1, cfg_otrip=3'd5, cfg_vtrip=3'd2 -> ena=1, otrip=5, vtrip=2 after 1 edge; state=SETTLE for 64 cycles then MONITOR; bod_out pulse during SETTLE -> no flag, sys_resetb stays 1.
- Brownout event: in MONITOR, bod_out high 20 cycles then low -> sys_resetb low 3 edges after the rise; brout_flag=1, irq=1. sys_resetb returns high exactly 3+20+8+256 cycles after the rise (±1 synchronizer skew), then state=MONITOR.
- Glitch during recovery: bod_out re-pulses for 1 cycle 100 cycles into HOLD -> state BROWNOUT, debounce restarts, full 8+256-cycle sequence repeats, sys_resetb never glitches high.
- Retune and disable: in MONITOR change cfg_otrip 5->6 -> state SETTLE, otrip=6, 64-cycle blanking. Then cfg_en=0 -> OFF, ena=0 next edge.
- Flags: bod_vunder high in MONITOR -> vunder_flag=1, state unchanged. clr_vunder with bod_vunder still high -> flag stays 1. Release bod_vunder, then clr_vunder -> vunder_flag=0, irq=0.
- Async reset mid-HOLD: resetb low -> all outputs reach reset values immediately, with no clock edge needed (sys_resetb=1, ena=0, state=OFF).
